mdu_iter: RTL
=============

// Module: mdu_iter
// PURPOSE
//  Iterative multiply/divide unit for the OpenMIPS EX stage: the parametrised successor of the fixed
//  32-bit divider. Adds operand width, signed/unsigned modes, an optional iterative multiply path and a
//  divide-by-zero flag. Sits beside EX; EX raises stallreq while busy_o=1 and writes HI/LO from result_o.
// PARAMETERS
//  WIDTH      32   operand width in bits, >=8; result_o is 2*WIDTH.
//  CNT_W      6    iteration counter width; must satisfy 2**CNT_W > WIDTH.
// PORTS
//  clk              in   1        clock, rising edge.
//  rst              in   1        asynchronous, active-high reset.
//  start_i          in   1        request; held high by EX until result_ready_o has been seen.
//  op_i             in   2        00 DIVU, 01 DIV, 10 MULTU, 11 MULT; sampled on accept.
//  opdata1_i        in   WIDTH    dividend / multiplicand; sampled on accept.
//  opdata2_i        in   WIDTH    divisor / multiplier; sampled on accept.
//  annul_i          in   1        abort the current operation (branch/exception flush).
//  busy_o           out  1        1 in DIVZERO and ON.
//  result_o         out  2*WIDTH  {HI,LO}: div = {remainder,quotient}; mul = full product.
//  result_ready_o   out  1        1 in END only.
//  divzero_o        out  1        1 with result_ready_o when the divisor was 0.
// BEHAVIOUR
//  - Reset (any time, including mid-operation): state=IDLE, all outputs 0, internal registers cleared.
//  - FSM: IDLE -> (start_i & ~annul_i) -> DIVZERO if div op and opdata2_i==0, else ON.
//    DIVZERO -> END next cycle (result 0, divzero_o=1). ON -> END after WIDTH iterations.
//    END -> IDLE when start_i=0; result_o/result_ready_o are held while start_i=1.
//  - annul_i=1 in DIVZERO or ON -> IDLE next edge, no result_ready_o. annul_i in END is ignored.
//  - Operands and op are latched on accept; input changes while busy are ignored; start_i while busy is ignored.
//  - Signed ops: magnitudes are iterated, signs fixed up in the last ON cycle. Quotient is negative iff the
//    operand signs differ; the remainder takes the dividend sign. Product sign = XOR of signs.
//  - Divide: restoring, 1 quotient bit/cycle, MSB first; WIDTH+1-bit partial remainder compare/subtract.
//  - Overflow case DIV min_neg / -1: quotient = min_neg (wraps), remainder = 0; no flag.
//  - Latency: accept at edge E -> result_ready_o high from edge E+WIDTH+1 (normal) or E+2 (divide-by-zero).
//  - Back-to-back: a new accept needs one IDLE cycle with start_i=0 first.
// CONFIGURATION
//  MDU_MUL_EN defined: MULT/MULTU run shift-add, 1 multiplier bit/cycle, same WIDTH+1 latency as divide.
//  MDU_MUL_EN undefined: the mul datapath is absent. A MULT/MULTU request goes IDLE->END in one cycle with
//  result_o=0 and divzero_o=0, so EX never deadlocks; EX uses its combinational multiplier instead.
// STRUCTURE
//  - Shared package mdu_pkg: op codes (MDU_DIVU/DIV/MULTU/MULT), state encodings
//    (IDLE/DIVZERO/ON/END), and the sign-fixup helper function.
//  - One sub-module, mdu_div_step: combinational restoring step that takes the partial remainder and
//    the divisor and returns the next partial remainder and the quotient bit.
//  - Top level: FSM, counter, operand/accumulator registers, and the MDU_MUL_EN shift-add step.
// TESTING
//  1. DIVU 100/7, WIDTH=32 -> result_ready_o at accept+33, result_o={32'd2,32'd14}, divzero_o=0.
//  2. DIV -7/2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1). DIV 32'h8000_0000/-1 -> LO=32'h8000_0000, HI=0.
//  3. DIVU 5/0 -> busy_o for 1 cycle; result_ready_o=1 and divzero_o=1 at accept+2; result_o=0.
//  4. annul_i pulse 10 cycles after accept -> busy_o=0 next cycle, result_ready_o never asserts;
//     a new DIVU 9/3 then returns LO=3, HI=0.
//  5. start_i held 5 cycles after ready -> result_o stable; drop start_i -> IDLE; assert rst mid-ON -> all outputs 0.
//  6. MDU_MUL_EN: MULT 32'hFFFF_FFFF*2 -> result_o=64'hFFFF_FFFF_FFFF_FFFE at accept+33.
//     Without the macro: ready at accept+1 with result_o=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, FSM states and sign-fixup helper for mdu_iter
//
// Purpose: common definitions imported by mdu_iter and mdu_div_step.
// Ports:   none (package).
package mdu_pkg;

  localparam logic [1:0] MDU_DIVU  = 2'b00;
  localparam logic [1:0] MDU_DIV   = 2'b01;
  localparam logic [1:0] MDU_MULTU = 2'b10;
  localparam logic [1:0] MDU_MULT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIVZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } mdu_state_t;

  function automatic logic op_is_mul(input logic [1:0] op);
    return (op == MDU_MULTU) || (op == MDU_MULT);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_MULT);
  endfunction

  // Decides which halves of the magnitude result must be negated: {hi_neg, lo_neg}.
  // Divide: remainder follows the dividend sign, quotient is negative when signs differ.
  // Multiply: the whole product is negated as one value, so both flags carry the XOR.
  function automatic logic [1:0] fix_signs(input logic is_mul, input logic sign_a,
                                           input logic sign_b);
    logic neg;
    neg = sign_a ^ sign_b;
    if (is_mul) return {neg, neg};
    return {sign_a, neg};
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
//
// Purpose: compare/subtract the divisor from a WIDTH+1-bit partial remainder.
// Ports:
//   part_rem  in   WIDTH+1  shifted partial remainder {rem, next dividend bit}
//   divisor   in   WIDTH    divisor magnitude
//   rem_next  out  WIDTH    next partial remainder (always < divisor, so WIDTH bits suffice)
//   q_bit     out  1        quotient bit produced by this step
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  import mdu_pkg::*;

  logic [WIDTH:0] diff;

  // part_rem < 2*divisor, so a non-negative difference never reaches bit WIDTH;
  // a set MSB therefore means the subtraction borrowed.
  assign diff     = part_rem - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : part_rem[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit for the EX stage
//
// Purpose: restoring divider (and optional shift-add multiplier) producing {HI,LO}.
// Config macro: MDU_MUL_EN - when defined MULT/MULTU iterate; otherwise they complete
//               immediately with a zero result.
// Ports:
//   clk             in   1        clock, rising edge
//   rst             in   1        asynchronous active-high reset
//   start_i         in   1        request, held until result_ready_o is seen
//   op_i            in   2        00 DIVU, 01 DIV, 10 MULTU, 11 MULT
//   opdata1_i       in   WIDTH    dividend / multiplicand
//   opdata2_i       in   WIDTH    divisor / multiplier
//   annul_i         in   1        abort the running operation
//   busy_o          out  1        high in DIVZERO and ON
//   result_o        out  2*WIDTH  {HI,LO}, valid while result_ready_o
//   result_ready_o  out  1        high in END
//   divzero_o       out  1        divide-by-zero flag, valid with result_ready_o
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               result_ready_o,
  output logic               divzero_o
);
  import mdu_pkg::*;

  mdu_state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic               is_mul_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic               divzero_q;
  // hi_q/lo_q: partial remainder/dividend-quotient for divide, product halves for multiply.
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  // opnd_q: divisor magnitude for divide, multiplicand magnitude for multiply.
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] result_q;

  logic               accept;
  logic               last_iter;
  logic               req_mul;
  logic               req_signed;
  logic               req_divzero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH-1:0]   div_rem_next;
  logic               div_q_bit;
  logic [WIDTH-1:0]   div_lo_next;
  logic [WIDTH-1:0]   mul_hi_next;
  logic [WIDTH-1:0]   mul_lo_next;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [1:0]         signs;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] final_result;

  assign req_mul     = op_is_mul(op_i);
  assign req_signed  = op_is_signed(op_i);
  assign req_divzero = ~req_mul & (opdata2_i == '0);
  // Magnitudes: negating the most negative value yields its correct unsigned magnitude.
  assign mag_a       = (req_signed & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag_b       = (req_signed & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign last_iter   = (cnt_q == CNT_W'(WIDTH - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    busy_o         = 1'b0;
    result_ready_o = 1'b0;
    result_o       = '0;
    divzero_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !annul_i) begin
          accept = 1'b1;
          if (req_divzero) begin
            state_d = ST_DIVZERO;
          end else begin
`ifdef MDU_MUL_EN
            state_d = ST_ON;
`else
            // No multiply datapath: answer at once so EX cannot deadlock.
            state_d = req_mul ? ST_END : ST_ON;
`endif
          end
        end
      end
      ST_DIVZERO: begin
        busy_o  = 1'b1;
        state_d = annul_i ? ST_IDLE : ST_END;
      end
      ST_ON: begin
        busy_o = 1'b1;
        if (annul_i)        state_d = ST_IDLE;
        else if (last_iter) state_d = ST_END;
      end
      ST_END: begin
        result_ready_o = 1'b1;
        result_o       = result_q;
        divzero_o      = divzero_q;
        if (!start_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .part_rem (({hi_q, lo_q[WIDTH-1]})),
    .divisor  (opnd_q),
    .rem_next (div_rem_next),
    .q_bit    (div_q_bit)
  );

  // Dividend bits leave at the top of lo_q while quotient bits enter at the bottom.
  assign div_lo_next = {lo_q[WIDTH-2:0], div_q_bit};

`ifdef MDU_MUL_EN
  logic [WIDTH:0] mul_sum;

  // Shift-add: add multiplicand when the current multiplier LSB is set, then shift
  // the whole {carry, hi, lo} right by one so product bits fill lo from the top.
  always_comb begin
    mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};
  end
`else
  assign mul_hi_next = '0;
  assign mul_lo_next = '0;
`endif

  assign step_hi = is_mul_q ? mul_hi_next : div_rem_next;
  assign step_lo = is_mul_q ? mul_lo_next : div_lo_next;

  // Sign fix-up is applied to the outcome of the final iteration in the same cycle.
  always_comb begin
    signs = fix_signs(is_mul_q, sign_a_q, sign_b_q);
    prod  = {step_hi, step_lo};
    if (is_mul_q)
      final_result = signs[0] ? -prod : prod;
    else
      final_result = {(signs[1] ? -step_hi : step_hi), (signs[0] ? -step_lo : step_lo)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      is_mul_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      is_mul_q  <= req_mul;
      sign_a_q  <= req_signed & opdata1_i[WIDTH-1];
      sign_b_q  <= req_signed & opdata2_i[WIDTH-1];
      divzero_q <= req_divzero;
      hi_q      <= '0;
      result_q  <= '0;
      if (req_mul) begin
        lo_q   <= mag_b;
        opnd_q <= mag_a;
      end else begin
        lo_q   <= mag_a;
        opnd_q <= mag_b;
      end
    end else if (state_q == ST_ON) begin
      cnt_q <= cnt_q + CNT_W'(1);
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      if (last_iter) result_q <= final_result;
    end
  end

endmodule
